bram_port_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port BRAM (addr/ce/we/d/q interface, 1-cycle read latency) between two masters.
- Typical pairing: the accumulate accessor writing results, and the host/readback path reading them.
- Grants per beat with round-robin fairness and a bounded burst lock; registers the winning beat onto the BRAM port and returns read data to the issuing requester.

---
 rtl/bram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin, burst-limited sharing of one single-port BRAM between two requesters
// Ports: clk/reset (sync, active high); r0_*/r1_* requester beats (req/we/addr/d in, gnt/rvalid/q out);
// addr_o/ce_o/we_o/d_o drive the BRAM port one cycle after grant; q_i is BRAM read data (1-cycle latency).
module bram_port_arbiter #(
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 8,
    parameter int MAX_BURST = 16,
    parameter int BCNT_BIT  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [AWIDTH-1:0] r0_addr_i,
    input  logic [DWIDTH-1:0] r0_d_i,
    output logic              r0_gnt_o,
    output logic              r0_rvalid_o,
    output logic [DWIDTH-1:0] r0_q_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [AWIDTH-1:0] r1_addr_i,
    input  logic [DWIDTH-1:0] r1_d_i,
    output logic              r1_gnt_o,
    output logic              r1_rvalid_o,
    output logic [DWIDTH-1:0] r1_q_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic              ce_o,
    output logic              we_o,
    output logic [DWIDTH-1:0] d_o,
    input  logic [DWIDTH-1:0] q_i
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [BCNT_BIT-1:0] MAXB = BCNT_BIT'(MAX_BURST);
    localparam logic [BCNT_BIT-1:0] ONE  = BCNT_BIT'(1);
    state_t              state_q, state_d;
    logic [BCNT_BIT-1:0] bcnt_q, bcnt_d;
    logic                last_q, last_d;
    logic                gnt0, gnt1;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   d_q, q0_q, q1_q;
    logic                ce_q, we_q;
    logic                rd_p1_q, rd_p2_q, own_p1_q, own_p2_q;
    logic                r0_rv, r1_rv;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            // tie from idle goes to whoever was not served last
            IDLE: begin
                gnt0 = r0_req_i && (!r1_req_i || last_q);
                gnt1 = r1_req_i && !gnt0;
            end
            // owner keeps the port until its burst is used up while the other waits
            OWN0: begin
                gnt0 = r0_req_i && (!r1_req_i || bcnt_q < MAXB);
                gnt1 = r1_req_i && !gnt0;
            end
            OWN1: begin
                gnt1 = r1_req_i && (!r0_req_i || bcnt_q < MAXB);
                gnt0 = r0_req_i && !gnt1;
            end
            default: ;
        endcase
        if (gnt0) begin
            state_d = OWN0;
            bcnt_d  = (state_q != OWN0) ? ONE : (bcnt_q == MAXB) ? bcnt_q : bcnt_q + ONE;
            last_d  = 1'b0;
        end else if (gnt1) begin
            state_d = OWN1;
            bcnt_d  = (state_q != OWN1) ? ONE : (bcnt_q == MAXB) ? bcnt_q : bcnt_q + ONE;
            last_d  = 1'b1;
        end else begin
            state_d = IDLE;
            bcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bcnt_q   <= '0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            d_q      <= '0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            rd_p1_q  <= 1'b0;
            rd_p2_q  <= 1'b0;
            own_p1_q <= 1'b0;
            own_p2_q <= 1'b0;
            q0_q     <= '0;
            q1_q     <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            last_q   <= last_d;
            ce_q     <= gnt0 || gnt1;
            we_q     <= gnt0 ? r0_we_i : (gnt1 && r1_we_i);
            if (gnt0 || gnt1) begin
                addr_q <= gnt1 ? r1_addr_i : r0_addr_i;
                d_q    <= gnt1 ? r1_d_i : r0_d_i;
            end
            // owner tag travels with each read so interleaved returns are routed correctly
            rd_p1_q  <= (gnt0 && !r0_we_i) || (gnt1 && !r1_we_i);
            own_p1_q <= gnt1;
            rd_p2_q  <= rd_p1_q;
            own_p2_q <= own_p1_q;
            if (r0_rv) q0_q <= q_i;
            if (r1_rv) q1_q <= q_i;
        end
    end

    assign r0_rv       = rd_p2_q && !own_p2_q && !reset;
    assign r1_rv       = rd_p2_q && own_p2_q && !reset;
    assign r0_gnt_o    = gnt0 && !reset;
    assign r1_gnt_o    = gnt1 && !reset;
    assign r0_rvalid_o = r0_rv;
    assign r1_rvalid_o = r1_rv;
    assign r0_q_o      = r0_rv ? q_i : q0_q;
    assign r1_q_o      = r1_rv ? q_i : q1_q;
    assign addr_o      = addr_q;
    assign d_o         = d_q;
    assign ce_o        = ce_q;
    assign we_o        = we_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and randomized checks of bram_port_arbiter against a cycle-level reference model
module tb_bram_port_arbiter;
    localparam int MAXB = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [7:0]  r0_addr = '0, r1_addr = '0;
    logic [63:0] r0_d = '0, r1_d = '0;
    logic        r0_gnt_o, r0_rvalid_o, r1_gnt_o, r1_rvalid_o, ce_o, we_o;
    logic [63:0] r0_q_o, r1_q_o, d_o, q_i = '0;
    logic [7:0]  addr_o;
    logic [63:0] mem [256];
    logic [63:0] mm [256];
    int checks = 0, errors = 0;

    bram_port_arbiter #(.DWIDTH(64), .AWIDTH(8), .MAX_BURST(MAXB), .BCNT_BIT(5)) dut (
        .clk(clk), .reset(reset),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_d_i(r0_d),
        .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o), .r0_q_o(r0_q_o),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_d_i(r1_d),
        .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o), .r1_q_o(r1_q_o),
        .addr_o(addr_o), .ce_o(ce_o), .we_o(we_o), .d_o(d_o), .q_i(q_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce_o === 1'b1) begin
            if (we_o) mem[addr_o] <= d_o;
            else q_i <= mem[addr_o];
        end
    end

    // reference model: arbitration rules, memory contents in grant order, expected returns two cycles later
    int cur = -1, run = 0, last = 1, g, s1o = 0, s2o = 0;
    logic ev = 0, ew = 0, s1v = 0, s2v = 0;
    logic [7:0] ea = '0;
    logic [63:0] ed = '0, s1d = '0, s2d = '0, h0 = '0, h1 = '0;

    always @(negedge clk) begin
        if (reset) begin
            cur = -1; run = 0; last = 1; s1v = 0; s2v = 0;
            ev = 0; ew = 0; ea = '0; ed = '0; h0 = '0; h1 = '0;
            checks++;
            if (r0_gnt_o !== 1'b0 || r1_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL model_reset_gnt: got gnt=%b%b want 00", r0_gnt_o, r1_gnt_o);
            end
        end else begin
            checks++;
            if ({ce_o, we_o, addr_o, d_o} !== {ev, ew, ea, ed}) begin
                errors++;
                $display("FAIL model_issue: got ce=%b we=%b a=%h d=%h want ce=%b we=%b a=%h d=%h",
                         ce_o, we_o, addr_o, d_o, ev, ew, ea, ed);
            end
            if (s2v && s2o == 0) h0 = s2d;
            if (s2v && s2o == 1) h1 = s2d;
            checks++;
            if (r0_rvalid_o !== (s2v && s2o == 0) || r0_q_o !== h0) begin
                errors++;
                $display("FAIL model_r0_ret: got v=%b q=%h want v=%b q=%h", r0_rvalid_o, r0_q_o, s2v && s2o == 0, h0);
            end
            checks++;
            if (r1_rvalid_o !== (s2v && s2o == 1) || r1_q_o !== h1) begin
                errors++;
                $display("FAIL model_r1_ret: got v=%b q=%h want v=%b q=%h", r1_rvalid_o, r1_q_o, s2v && s2o == 1, h1);
            end
            if (!r0_req && !r1_req) g = -1;
            else if (r0_req != r1_req) g = r0_req ? 0 : 1;
            else if (cur >= 0 && run < MAXB) g = cur;
            else if (cur >= 0) g = 1 - cur;
            else g = 1 - last;
            checks++;
            if (r0_gnt_o !== (g == 0) || r1_gnt_o !== (g == 1)) begin
                errors++;
                $display("FAIL model_gnt: got gnt=%b%b want %b%b", r0_gnt_o, r1_gnt_o, g == 0, g == 1);
            end
            s2v = s1v; s2o = s1o; s2d = s1d;
            if (g < 0) begin
                cur = -1; run = 0; s1v = 0; ev = 0; ew = 0;
            end else begin
                run = (g == cur) ? ((run < MAXB) ? run + 1 : run) : 1;
                cur = g; last = g; ev = 1;
                ew = g ? r1_we : r0_we;
                ea = g ? r1_addr : r0_addr;
                ed = g ? r1_d : r0_d;
                s1v = !ew; s1o = g; s1d = mm[ea];
                if (ew) mm[ea] = ed;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
        tick(); tick(); #2;
        checks++;
        if ({ce_o, we_o, addr_o, d_o} !== '0) begin
            errors++; $display("FAIL reset_port: got ce=%b we=%b a=%h d=%h want 0", ce_o, we_o, addr_o, d_o);
        end
        checks++;
        if ({r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o} !== 4'b0 || r0_q_o !== '0 || r1_q_o !== '0) begin
            errors++; $display("FAIL reset_req: got gnt=%b%b rv=%b%b q0=%h q1=%h want 0",
                               r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, r0_q_o, r1_q_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        r0_req = 1; r0_we = 0; r0_addr = 8'h05; #2;
        checks++;
        if ({r0_gnt_o, r1_gnt_o} !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b%b want 10", r0_gnt_o, r1_gnt_o); end
        tick(); r0_req = 0; #2;
        checks++;
        if ({ce_o, we_o, addr_o} !== {2'b10, 8'h05}) begin
            errors++; $display("FAIL single_issue: got ce=%b we=%b a=%h want 1 0 05", ce_o, we_o, addr_o);
        end
        tick(); #2;
        checks++;
        if (r0_rvalid_o !== 1'b1 || r0_q_o !== 64'h1122) begin
            errors++; $display("FAIL single_ret: got v=%b q=%h want 1 1122", r0_rvalid_o, r0_q_o);
        end
        checks++;
        if (r1_rvalid_o !== 1'b0 || r1_q_o !== '0 || r1_gnt_o !== 1'b0) begin
            errors++; $display("FAIL single_r1_quiet: got v=%b q=%h g=%b want 0", r1_rvalid_o, r1_q_o, r1_gnt_o);
        end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        r0_req = 1; r0_we = 0; r0_addr = 8'h01; r1_req = 1; r1_we = 0; r1_addr = 8'h02; #2;
        checks++;
        if ({r0_gnt_o, r1_gnt_o} !== 2'b10) begin errors++; $display("FAIL tie_first: got %b%b want 10", r0_gnt_o, r1_gnt_o); end
        tick(); r0_req = 0; #2;
        checks++;
        if ({r0_gnt_o, r1_gnt_o} !== 2'b01) begin errors++; $display("FAIL tie_second: got %b%b want 01", r0_gnt_o, r1_gnt_o); end
        tick(); r1_req = 0; tick();
        r0_req = 1; r1_req = 1; #2;
        checks++;
        if ({r0_gnt_o, r1_gnt_o} !== 2'b10) begin errors++; $display("FAIL tie_after_r1: got %b%b want 10", r0_gnt_o, r1_gnt_o); end
        tick(); r0_req = 0; tick(); r1_req = 0; tick();
        r0_req = 1; tick(); r0_req = 0; tick();
        r0_req = 1; r1_req = 1; #2;
        checks++;
        if ({r0_gnt_o, r1_gnt_o} !== 2'b01) begin errors++; $display("FAIL tie_after_r0: got %b%b want 01", r0_gnt_o, r1_gnt_o); end
        tick(); r1_req = 0; tick(); r0_req = 0; tick();
    endtask

    task automatic test_burst();
        do_reset();
        r0_req = 1; r0_we = 0; r0_addr = 8'h40; r1_req = 1; r1_we = 0; r1_addr = 8'h41;
        for (int k = 0; k < 3 * MAXB; k++) begin
            #2;
            checks++;
            if (r0_gnt_o !== ((k / MAXB) % 2 == 0) || r1_gnt_o !== ((k / MAXB) % 2 == 1)) begin
                errors++; $display("FAIL burst_gnt[%0d]: got %b%b want %b%b", k, r0_gnt_o, r1_gnt_o,
                                   (k / MAXB) % 2 == 0, (k / MAXB) % 2 == 1);
            end
            if (k > 0) begin
                checks++;
                if (ce_o !== 1'b1) begin errors++; $display("FAIL burst_ce[%0d]: got %b want 1", k, ce_o); end
            end
            tick();
        end
        r0_req = 0; r1_req = 0; tick(); tick(); tick();
    endtask

    task automatic test_interleave();
        r0_req = 1; r0_we = 0; r0_addr = 8'h10; #2;
        checks++;
        if (r0_gnt_o !== 1'b1) begin errors++; $display("FAIL ilv_g0: got %b want 1", r0_gnt_o); end
        tick(); r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 8'h20; #2;
        checks++;
        if (r1_gnt_o !== 1'b1) begin errors++; $display("FAIL ilv_g1: got %b want 1", r1_gnt_o); end
        tick(); r1_req = 0; #2;
        checks++;
        if ({r0_rvalid_o, r1_rvalid_o} !== 2'b10 || r0_q_o !== 64'hAA) begin
            errors++; $display("FAIL ilv_r0: got rv=%b%b q0=%h want 10 aa", r0_rvalid_o, r1_rvalid_o, r0_q_o);
        end
        tick(); #2;
        checks++;
        if ({r0_rvalid_o, r1_rvalid_o} !== 2'b01 || r1_q_o !== 64'hBB) begin
            errors++; $display("FAIL ilv_r1: got rv=%b%b q1=%h want 01 bb", r0_rvalid_o, r1_rvalid_o, r1_q_o);
        end
        tick();
    endtask

    task automatic test_raw();
        r1_req = 1; r1_we = 1; r1_addr = 8'h30; r1_d = 64'hDEAD; #2;
        checks++;
        if (r1_gnt_o !== 1'b1) begin errors++; $display("FAIL raw_gw: got %b want 1", r1_gnt_o); end
        tick(); r1_req = 0; r0_req = 1; r0_we = 0; r0_addr = 8'h30; #2;
        checks++;
        if ({r0_gnt_o, ce_o, we_o, addr_o, d_o} !== {3'b111, 8'h30, 64'hDEAD}) begin
            errors++; $display("FAIL raw_write: got g0=%b ce=%b we=%b a=%h d=%h want 1 1 1 30 dead",
                               r0_gnt_o, ce_o, we_o, addr_o, d_o);
        end
        tick(); r0_req = 0; #2;
        checks++;
        if ({ce_o, we_o} !== 2'b10) begin errors++; $display("FAIL raw_read_issue: got ce=%b we=%b want 1 0", ce_o, we_o); end
        tick(); #2;
        checks++;
        if ({r0_rvalid_o, r1_rvalid_o} !== 2'b10 || r0_q_o !== 64'hDEAD) begin
            errors++; $display("FAIL raw_ret: got rv=%b%b q0=%h want 10 dead", r0_rvalid_o, r1_rvalid_o, r0_q_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        r0_req = 1; r0_we = 0; r0_addr = 8'h05; #2;
        checks++;
        if (r0_gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid_g: got %b want 1", r0_gnt_o); end
        tick(); r0_req = 0; reset = 1; tick(); reset = 0; #2;
        checks++;
        if ({r0_rvalid_o, r1_rvalid_o, ce_o, we_o} !== 4'b0 || addr_o !== '0 || d_o !== '0 || r0_q_o !== '0 || r1_q_o !== '0) begin
            errors++; $display("FAIL rstmid_out: got rv=%b%b ce=%b we=%b a=%h d=%h q0=%h q1=%h want 0",
                               r0_rvalid_o, r1_rvalid_o, ce_o, we_o, addr_o, d_o, r0_q_o, r1_q_o);
        end
        tick(); #2;
        checks++;
        if ({r0_rvalid_o, r1_rvalid_o} !== 2'b00) begin
            errors++; $display("FAIL rstmid_late: got rv=%b%b want 00", r0_rvalid_o, r1_rvalid_o);
        end
        tick(); r0_req = 1; r1_req = 1; r1_we = 0; #2;
        checks++;
        if ({r0_gnt_o, r1_gnt_o} !== 2'b10) begin errors++; $display("FAIL rstmid_tie: got %b%b want 10", r0_gnt_o, r1_gnt_o); end
        tick(); r0_req = 0; tick(); r1_req = 0; tick(); tick();
    endtask

    task automatic test_random();
        logic g0, g1;
        for (int c = 0; c < 500; c++) begin
            #2;
            g0 = r0_gnt_o; g1 = r1_gnt_o;
            checks++;
            if ((g0 && g1) || (g0 && !r0_req) || (g1 && !r1_req)) begin
                errors++; $display("FAIL rand_gnt_legal[%0d]: got gnt=%b%b with req=%b%b", c, g0, g1, r0_req, r1_req);
            end
            tick();
            if (g0 || !r0_req) begin
                r0_req = $urandom_range(0, 3) != 0; r0_we = $urandom_range(0, 1) == 1;
                r0_addr = 8'($urandom_range(0, 15)); r0_d = {$urandom, $urandom};
            end
            if (g1 || !r1_req) begin
                r1_req = $urandom_range(0, 3) != 0; r1_we = $urandom_range(0, 1) == 1;
                r1_addr = 8'($urandom_range(0, 15)); r1_d = {$urandom, $urandom};
            end
        end
        r0_req = 0; r1_req = 0;
        tick(); tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom};
        end
        mem[8'h05] = 64'h1122; mem[8'h10] = 64'hAA; mem[8'h20] = 64'hBB;
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        test_reset();
        test_single_read();
        test_tie();
        test_burst();
        test_interleave();
        test_raw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
